floppy_spi_host: RTL
====================

Name: floppy_spi_host

Overview:
- Parametrised SD-card SPI host for the floppy emulation subsystem.
- Replaces the fixed wiring of the SD pins (card select tied high, no transfer engine) with a register-mapped byte and burst transfer engine.
- Has a selectable slow or fast SCK and a receive FIFO that the floppy CPU drains over its I/O bus.
- Sits between the floppy CPU I/O decode and the SD pins.

Parameters:
- DIV_SLOW, 64: SCK half-period in clk cycles in slow (init) mode; must be ≥1.
- DIV_FAST, 2: SCK half-period in clk cycles in fast mode; must be ≥1.
- CNT_W, 10: burst counter width; the maximum burst is 2^CNT_W−1 bytes.
- FIFO_DEPTH, 4: receive FIFO depth; must be a power of two, ≥2.
- FILL, 8'hFF: byte transmitted on MOSI during a burst.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- addr  in  2  register select: 0 = data, 1 = control/status, 2 = count low, 3 = count high.
- wr  in  1  one-cycle write strobe.
- rd  in  1  one-cycle read strobe; a read with addr=0 pops the FIFO.
- idata  in  8  write data.
- odata  out  8  read data; combinational mux of addr.
- busy  out  1  engine active.
- sd_clk  out  1  SPI SCK.
- sd_cs_n  out  1  card select, active low.
- sd_mosi  out  1  SPI data out.
- sd_miso  in  1  SPI data in; assumed synchronised by the caller.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - sd_clk=0, sd_cs_n=1, sd_mosi=1, busy=0.
  - FIFO empty, count=0, slow mode, overflow flag=0, state IDLE.
  - A reset during a transfer aborts it immediately with no FIFO push.
- Register writes:
  - addr0, while IDLE and FIFO not full: loads the TX byte and starts a single transfer.
  - addr0, while IDLE and FIFO full: write dropped, overflow set.
  - addr0, while busy: ignored.
  - addr1: bit0 cs (sd_cs_n = ~bit0), bit1 fast, bit2 burst start, bit3 abort.
  - addr1 while busy: cs, fast and start are ignored; only abort is honoured.
  - addr2 / addr3: count[7:0] / count[CNT_W-1:8]. Ignored while busy.
- Register reads:
  - addr0: FIFO head, which is then popped; 8'hFF with no pop when empty.
  - addr1 status: bit0 busy, bit1 data available, bit2 FIFO full, bit3 fast, bit4 cs, bit5 overflow.
  - Reading status clears overflow on the same rd strobe.
  - addr2 / addr3: remaining count.
- Burst start with count=0: no-op; busy stays 0.
- Burst start with count>0:
  - Enters WAIT and shifts FILL bytes.
  - count decrements by 1 after each byte's push; the burst ends when it reaches 0.
- State machine IDLE→WAIT→SHIFT→PUSH:
  - IDLE→WAIT on a data write or burst start.
  - WAIT: sd_clk held low while the FIFO is full; goes to SHIFT when not full. The divider (DIV_FAST or DIV_SLOW) is latched on leaving WAIT.
  - SHIFT: 16 half-periods, mode 0, MSB first.
    - MOSI is set to bit7 on entry, and changes on each falling edge.
    - MISO is sampled on each rising edge.
    - sd_clk ends low.
  - PUSH: one cycle; the received byte is written to the FIFO.
  - After PUSH: back to WAIT if the burst is not done and no abort is pending, otherwise IDLE.
  - sd_mosi returns to 1 in IDLE.
- Byte latency: write strobe to FIFO push = 1 + 16·DIV + 1 cycles when the FIFO has space.
- Abort:
  - Sets a pending flag; the current byte completes and is pushed, then the engine goes to IDLE.
  - count keeps its remaining value.
  - Abort while IDLE has no effect.
- FIFO:
  - A push and pop in the same cycle both take effect, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
- busy=1 in WAIT, SHIFT and PUSH; busy=0 in IDLE.

Test Plan:
- Reset, then read status → 8'h00; sd_cs_n=1, sd_clk=0, sd_mosi=1.
- Write ctrl=8'h01, then data=8'hA5 with a MISO model returning 8'h3C, DIV_SLOW=64 →
  - exactly 8 SCK pulses, 64-cycle half-periods;
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - push 1 + 1024 + 1 cycles after the write;
  - data read returns 8'h3C.
- Count=10, ctrl=8'h07 (fast, DIV_FAST=2), CPU not reading → after 4 bytes the engine stalls in WAIT with status bit2=1 and sd_clk low. Pop one byte → exactly one more byte transfers.
- Drain concurrently during the above → 10 bytes are received in order; count reads 0; busy falls.
- Abort after byte 3 of a 100-byte burst → bytes 3 and 4 complete; count reads 96; IDLE.
- Fill the FIFO, write data=8'h00 → no SCK; overflow=1. Status read clears it; a second read → bit5=0.

Source files
------------

// File: rtl/floppy_spi_host.sv
// floppy_spi_host
//   SD-card SPI host for the floppy emulation subsystem. The floppy CPU
//   drives the SD pins through a small register file. Supported
//   operations are single-byte transfers (a data write) and FILL-byte
//   read bursts (a control write with the start bit set). Received bytes
//   are queued in a receive FIFO that the CPU drains by reading the data
//   register. SPI mode 0, MSB first, with a selectable slow or fast SCK.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   addr[1:0]          0 data, 1 control/status, 2 count low, 3 count high
//   wr, rd             one-cycle write / read strobes (rd of addr 0 pops)
//   idata[7:0]         write data
//   odata[7:0]         read data, combinational mux of addr
//   busy               engine active (WAIT, SHIFT or PUSH)
//   sd_clk, sd_cs_n    SPI SCK and active-low card select
//   sd_mosi, sd_miso   SPI data out / in (sd_miso already synchronised)
module floppy_spi_host #(
  parameter int unsigned DIV_SLOW   = 64,
  parameter int unsigned DIV_FAST   = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL       = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] idata,
  output logic [7:0] odata,
  output logic       busy,
  output logic       sd_clk,
  output logic       sd_cs_n,
  output logic       sd_mosi,
  input  logic       sd_miso
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DIV_W-1:0] RELOAD_SLOW = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0] RELOAD_FAST = DIV_W'(DIV_FAST - 1);
  localparam logic [PTR_W:0]   LVL_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_PUSH
  } state_t;

  state_t             state;
  logic [7:0]         tx_byte;
  logic [6:0]         tx_sh;       // bits still to be driven after the current one
  logic [7:0]         rx_sh;
  logic               burst;
  logic               abort_pend;
  logic               fast;
  logic               overflow;
  logic [CNT_W-1:0]   count;
  logic [DIV_W-1:0]   div_reload;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         half_cnt;

  // Receive FIFO
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W:0]     level;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;

  // Bus decode
  logic               wr_data;
  logic               wr_ctrl;
  logic               wr_lo;
  logic               wr_hi;
  logic               rd_data;
  logic               rd_stat;
  logic               abort_req;
  logic               last_byte;
  logic [7:0]         tx_load;
  logic [7:0]         status;
  logic [15:0]        cnt_ext;

  assign wr_data   = wr && (addr == 2'd0);
  assign wr_ctrl   = wr && (addr == 2'd1);
  assign wr_lo     = wr && (addr == 2'd2);
  assign wr_hi     = wr && (addr == 2'd3);
  assign rd_data   = rd && (addr == 2'd0);
  assign rd_stat   = rd && (addr == 2'd1);

  assign busy      = (state != S_IDLE);
  assign abort_req = wr_ctrl && idata[3] && busy;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign push       = (state == S_PUSH);
  assign pop        = rd_data && !fifo_empty;

  assign tx_load   = burst ? FILL : tx_byte;
  // An abort written during PUSH itself is honoured on this byte boundary.
  assign last_byte = !burst || (count == CNT_W'(1)) || abort_pend || abort_req;

  assign cnt_ext   = 16'(count);
  assign status    = {2'b00, overflow, ~sd_cs_n, fast, fifo_full, ~fifo_empty, busy};

  always_comb begin
    odata = 8'hFF;
    case (addr)
      2'd0:    odata = fifo_empty ? 8'hFF : mem[rptr];
      2'd1:    odata = status;
      2'd2:    odata = cnt_ext[7:0];
      default: odata = cnt_ext[15:8];
    endcase
  end

  // FIFO storage: no reset needed, validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sd_clk     <= 1'b0;
      sd_cs_n    <= 1'b1;
      sd_mosi    <= 1'b1;
      tx_byte    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      burst      <= 1'b0;
      abort_pend <= 1'b0;
      fast       <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
      div_reload <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
    end else begin
      if (rd_stat)   overflow   <= 1'b0;
      if (abort_req) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          sd_clk     <= 1'b0;
          sd_mosi    <= 1'b1;
          abort_pend <= 1'b0;
          if (wr_data) begin
            if (fifo_full) begin
              overflow <= 1'b1;
            end else begin
              tx_byte <= idata;
              burst   <= 1'b0;
              state   <= S_WAIT;
            end
          end
          if (wr_ctrl) begin
            sd_cs_n <= ~idata[0];
            fast    <= idata[1];
            if (idata[2] && (count != '0)) begin
              burst <= 1'b1;
              state <= S_WAIT;
            end
          end
          if (wr_lo) count[7:0] <= idata;
          if (wr_hi) count      <= CNT_W'({idata, count[7:0]});
        end

        S_WAIT: begin
          sd_clk <= 1'b0;
          if (!fifo_full) begin
            state      <= S_SHIFT;
            sd_mosi    <= tx_load[7];
            tx_sh      <= tx_load[6:0];
            div_reload <= fast ? RELOAD_FAST : RELOAD_SLOW;
            div_cnt    <= fast ? RELOAD_FAST : RELOAD_SLOW;
            half_cnt   <= '0;
          end
        end

        S_SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt  <= div_reload;
            sd_clk   <= ~sd_clk;
            half_cnt <= half_cnt + 4'd1;
            if (!sd_clk) begin
              rx_sh <= {rx_sh[6:0], sd_miso};
            end else begin
              sd_mosi <= tx_sh[6];
              tx_sh   <= {tx_sh[5:0], 1'b0};
            end
            if (half_cnt == 4'd15) state <= S_PUSH;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        S_PUSH: begin
          if (burst) count <= count - 1'b1;
          if (last_byte) begin
            state      <= S_IDLE;
            sd_mosi    <= 1'b1;
            abort_pend <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
